// File: rtl/skew_pkg.sv
// Shared types and default constants for the skew measurement controller.
// Holds the FSM state type so checkers and the TDC wrapper agree on encoding.
package skew_pkg;

  localparam int SKEW_DEF_STAGES   = 64;
  localparam int SKEW_DEF_MAX_LOG2 = 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACCUM  = 2'd2,
    S_DONE   = 2'd3
  } skew_state_t;

endpackage

// File: rtl/skew_meas_ctrl.sv
// Skew measurement controller: settles the TDC, averages 2^n_eff clamped codes,
// tracks min/max/saturation and holds the result until acknowledged.
//
// Handshake: start is a one-cycle request honoured only in IDLE; result_valid
// stays high in DONE with all result fields stable, and the cycle on which
// result_ack=1 is seen in DONE is the transfer, after which the block is IDLE.
module skew_meas_ctrl
  import skew_pkg::*;
#(
  parameter int  STAGES   = SKEW_DEF_STAGES,
  parameter int  SETTLE   = 4,
  parameter int  MAX_LOG2 = SKEW_DEF_MAX_LOG2,
  localparam int CW       = $clog2(STAGES + 1),
  localparam int AW       = CW + MAX_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        n_log2,
  input  logic [CW-1:0]     skew_code,
  input  logic              result_ack,
  output logic              tdc_en,
  output logic              busy,
  output logic              result_valid,
  output logic [CW-1:0]     result_avg,
  output logic [CW-1:0]     result_min,
  output logic [CW-1:0]     result_max,
  output logic              result_sat,
  output skew_state_t       dbg_state
);

  localparam int            SW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int            NW       = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
  localparam logic [2:0]    NMAX     = (MAX_LOG2 > 7) ? 3'd7 : 3'(MAX_LOG2);
  localparam logic [CW-1:0] CODE_MAX = CW'(STAGES);

  skew_state_t r_state, w_state_nxt;

  logic [2:0]    r_n_eff;
  logic [SW-1:0] r_settle_cnt;
  logic [NW-1:0] r_cnt;
  logic [AW-1:0] r_acc;
  logic [CW-1:0] r_min, r_max;
  logic          r_sat;
  logic [CW-1:0] r_res_avg, r_res_min, r_res_max;
  logic          r_res_sat;

  logic [2:0]    w_n_eff;
  logic          w_over;
  logic [CW-1:0] w_sample;
  logic [AW-1:0] w_acc_next;
  logic [CW-1:0] w_min_next, w_max_next, w_avg;
  logic [NW-1:0] w_last_idx;
  logic          w_cnt_last, w_settle_last;

  assign w_n_eff       = (n_log2 > NMAX) ? NMAX : n_log2;
  assign w_over        = (skew_code > CODE_MAX);
  assign w_sample      = w_over ? CODE_MAX : skew_code;
  // AW = CW + MAX_LOG2 bits hold 2^MAX_LOG2 samples of at most STAGES each.
  assign w_acc_next    = r_acc + AW'(w_sample);
  assign w_min_next    = (w_sample < r_min) ? w_sample : r_min;
  assign w_max_next    = (w_sample > r_max) ? w_sample : r_max;
  assign w_avg         = CW'(w_acc_next >> r_n_eff);
  assign w_last_idx    = NW'((32'd1 << r_n_eff) - 32'd1);
  assign w_cnt_last    = (r_cnt == w_last_idx);
  assign w_settle_last = (SETTLE <= 1) || (r_settle_cnt == SW'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = (SETTLE == 0) ? S_ACCUM : S_SETTLE;
      S_SETTLE: begin
        if (abort)              w_state_nxt = S_IDLE;
        else if (w_settle_last) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (w_cnt_last) w_state_nxt = S_DONE;
      end
      S_DONE:   if (result_ack) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n_eff      <= '0;
      r_settle_cnt <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_min        <= '0;
      r_max        <= '0;
      r_sat        <= 1'b0;
      r_res_avg    <= '0;
      r_res_min    <= '0;
      r_res_max    <= '0;
      r_res_sat    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n_eff      <= w_n_eff;
            r_settle_cnt <= '0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_min        <= '1;
            r_max        <= '0;
            r_sat        <= 1'b0;
          end
        end
        S_SETTLE: r_settle_cnt <= r_settle_cnt + 1'b1;
        S_ACCUM: begin
          // An aborted cycle's sample is dropped; the partial state is cleared on the next start.
          if (!abort) begin
            r_acc <= w_acc_next;
            r_min <= w_min_next;
            r_max <= w_max_next;
            r_sat <= r_sat | w_over;
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_last) begin
              r_res_avg <= w_avg;
              r_res_min <= w_min_next;
              r_res_max <= w_max_next;
              r_res_sat <= r_sat | w_over;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tdc_en       = (r_state == S_SETTLE) || (r_state == S_ACCUM);
  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_DONE);
  assign result_avg   = r_res_avg;
  assign result_min   = r_res_min;
  assign result_max   = r_res_max;
  assign result_sat   = r_res_sat;
  assign dbg_state    = r_state;

endmodule

// File: doc/skew_meas_ctrl.md
SKEW_MEAS_CTRL -- requirements
Module: skew_meas_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 64: delay-chain stage count of the sampled skew TDC.
REQ-002 SHALL have parameter SETTLE, default 4: cycles to wait after tdc_en rises before sampling.
REQ-003 SHALL have parameter MAX_LOG2, default 7: largest allowed log2 of the sample count.
REQ-004 SHALL have the ports below; CW = $clog2(STAGES+1) and AW = CW+MAX_LOG2.
REQ-005 clk  input  1: single clock; skew_code is sampled by this clock.
REQ-006 rst_n  input  1: reset, synchronous, active-low.
REQ-007 start  input  1: one-cycle request to begin a measurement.
REQ-008 abort  input  1: cancel the measurement in progress.
REQ-009 n_log2  input  3: log2 of the number of samples to average.
REQ-010 skew_code  input  CW: thermometer-decoded TDC code.
REQ-011 result_ack  input  1: consumer accepts the result.
REQ-012 tdc_en  output  1: enables the TDC launch and sampling path.
REQ-013 busy  output  1: high in any state other than IDLE.
REQ-014 result_valid  output  1: result fields are valid.
REQ-015 result_avg, result_min, result_max  output  CW each: mean, minimum and maximum code.
REQ-016 result_sat  output  1: at least one sample exceeded STAGES.

Function
REQ-017 SHALL implement the states IDLE, SETTLE, ACCUM and DONE.
REQ-018 In IDLE, start=1 SHALL do all of the following:
- latch n_eff = min(n_log2, MAX_LOG2);
- clear the accumulator, min (to all-ones), max (to 0) and the sat flag;
- go to SETTLE.
REQ-019 start SHALL be ignored in SETTLE, ACCUM and DONE.
REQ-020 tdc_en SHALL be 1 exactly in SETTLE and ACCUM.
REQ-021 SETTLE SHALL last exactly SETTLE cycles; SETTLE=0 SHALL go straight to ACCUM.
REQ-022 ACCUM SHALL sample skew_code on exactly 2^n_eff consecutive cycles, using a sample counter.
REQ-023 A sample value greater than STAGES SHALL be clamped to STAGES and SHALL set the sat flag.
REQ-024 Each sample SHALL be added to an AW-bit accumulator, which SHALL never overflow.
REQ-025 Each sample SHALL update min and max, comparing after clamping.
REQ-026 On the cycle after the last sample, the block SHALL enter DONE with:
- result_avg = accumulator >> n_eff, truncated;
- result_min, result_max and result_sat registered.
REQ-027 Latency from start to result_valid SHALL be 1 + SETTLE + 2^n_eff cycles.
REQ-028 result_valid SHALL be 1 only in DONE, with all result fields stable until accepted.
REQ-029 In DONE, result_ack=1 SHALL return the block to IDLE on the next cycle.
REQ-030 result_ack outside DONE SHALL be ignored.
REQ-031 abort=1 in SETTLE or ACCUM SHALL go to IDLE next cycle, produce no result, and drop tdc_en next cycle.
REQ-032 abort SHALL be ignored in IDLE and DONE.
REQ-033 If abort and start are asserted together in IDLE, start SHALL win.
REQ-034 With n_eff=0, ACCUM SHALL last one cycle, and avg, min and max SHALL all equal that sample.

Reset
REQ-035 rst_n=0 SHALL, at the next clk edge, force the following, overriding all other inputs:
- state IDLE;
- tdc_en, busy, result_valid and result_sat = 0;
- result_avg, result_min and result_max = 0;
- counters and accumulator = 0.
REQ-036 Reset asserted mid-measurement SHALL discard all partial results.

Structure
REQ-037 A shared package skew_pkg SHALL hold the state enum type skew_state_t and the default constants for STAGES and MAX_LOG2.
REQ-038 The block SHALL be a single module with no sub-module; the TDC core SHALL be instantiated beside it at the top level.

Verification
REQ-039 STAGES=64, SETTLE=4, n_log2=2, skew_code held at 20 -> result_valid at cycle 9 after start, with avg=min=max=20 and sat=0.
REQ-040 n_log2=2, samples 10, 11, 12, 13 -> avg=11, min=10, max=13.
REQ-041 n_log2=7 and all samples 64 -> avg=64, with no accumulator overflow.
REQ-042 One sample of 100 -> clamped to 64 and result_sat=1.
REQ-043 abort asserted on the 2nd ACCUM cycle -> IDLE next cycle, tdc_en=0, and no result_valid.
REQ-044 n_log2=7 with MAX_LOG2=5 -> 32 samples; rst_n=0 during ACCUM -> all outputs 0 the next cycle.
